// File: rtl/nn_pkg.sv
// nn_pkg
// Shared definitions for the quantized MNIST network back end.
// Contents:
//   DATA_W, NUM_INPUTS, NUM_CLASSES, IDX_W : default vector geometry
//   argmax_state_t                         : state encoding of the argmax scanner
//   score_t                                : one signed network score
package nn_pkg;

  localparam int DATA_W      = 16;
  localparam int NUM_INPUTS  = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  typedef logic signed [DATA_W-1:0] score_t;

endpackage

// File: rtl/argmax_classifier.sv
// argmax_classifier
// Final classification stage: captures the first NUM_CLASSES scores of the
// upstream vector and scans them one per cycle, reporting the index and value
// of the largest score (lowest index wins on ties).
//
// Handshake: valid_in is a single-cycle strobe and is accepted whenever ready
// is high (state != SCAN). A result is presented for exactly one cycle with
// valid_out high; class_idx/max_value hold until the next result. A valid_in
// seen while ready is low is dropped and reported one cycle later on overrun.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   input_vector : NUM_INPUTS scores of DATA_W bits (two's complement)
//   valid_in     : input_vector strobe
//   ready        : block can accept valid_in this cycle
//   class_idx    : predicted class
//   max_value    : score of the predicted class
//   valid_out    : one-cycle result strobe
//   overrun      : one-cycle pulse after a rejected valid_in
//   dbg_state_o  : current scanner state
module argmax_classifier #(
  parameter int NUM_INPUTS  = nn_pkg::NUM_INPUTS,
  parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int IDX_W       = nn_pkg::IDX_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_INPUTS-1:0][DATA_W-1:0]   input_vector,
  input  logic                                valid_in,
  output logic                                ready,
  output logic [IDX_W-1:0]                    class_idx,
  output logic signed [DATA_W-1:0]            max_value,
  output logic                                valid_out,
  output logic                                overrun,
  output nn_pkg::argmax_state_t               dbg_state_o
);

  import nn_pkg::argmax_state_t;
  import nn_pkg::IDLE;
  import nn_pkg::SCAN;
  import nn_pkg::DONE;

  // Parameter legality, checked at elaboration.
  if (NUM_CLASSES < 2 || NUM_CLASSES > NUM_INPUTS) begin : g_bad_classes
    $error("argmax_classifier: NUM_CLASSES must lie in 2..NUM_INPUTS");
  end
  if ((1 << IDX_W) < NUM_CLASSES) begin : g_bad_idx_w
    $error("argmax_classifier: IDX_W too narrow for NUM_CLASSES");
  end

  // Padding neurons are never looked at.
  if (NUM_CLASSES < NUM_INPUTS) begin : g_pad
    logic pad_unused;
    assign pad_unused = ^input_vector[NUM_INPUTS-1:NUM_CLASSES];
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t state_q, state_d;
  logic signed [DATA_W-1:0] vec_q [NUM_CLASSES];
  logic signed [DATA_W-1:0] vec_d [NUM_CLASSES];
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]         run_idx_q, run_idx_d;
  logic [IDX_W-1:0]         class_q, class_d;
  logic signed [DATA_W-1:0] maxval_q, maxval_d;
  logic                     vout_q, vout_d;
  logic                     ovr_q, ovr_d;

  // Single comparator: the element under the counter against the running max.
  logic signed [DATA_W-1:0] cand;
  logic                     take;
  logic signed [DATA_W-1:0] post_max;
  logic [IDX_W-1:0]         post_idx;

  always_comb begin
    cand     = vec_q[cnt_q];
    take     = (cand > run_max_q);
    post_max = take ? cand  : run_max_q;
    post_idx = take ? cnt_q : run_idx_q;
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    class_d   = class_q;
    maxval_d  = maxval_q;
    vout_d    = 1'b0;
    ovr_d     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (valid_in) begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            vec_d[i] = input_vector[i];
          end
          run_max_d = input_vector[0];
          run_idx_d = '0;
          cnt_d     = IDX_W'(1);
          state_d   = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // A new vector mid-scan is dropped; the scan itself carries on.
        ovr_d     = valid_in;
        run_max_d = post_max;
        run_idx_d = post_idx;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          class_d  = post_idx;
          maxval_d = post_max;
          vout_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        vec_q[i] <= '0;
      end
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      class_q   <= '0;
      maxval_q  <= '0;
      vout_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      class_q   <= class_d;
      maxval_q  <= maxval_d;
      vout_q    <= vout_d;
      ovr_q     <= ovr_d;
    end
  end

  assign ready       = (state_q != SCAN);
  assign class_idx   = class_q;
  assign max_value   = maxval_q;
  assign valid_out   = vout_q;
  assign overrun     = ovr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier
// Self-checking bench for argmax_classifier: directed vectors for the
// documented corner cases plus randomized vectors, each checked against a
// plain-arithmetic argmax reference and an expected-result queue.
module tb_argmax_classifier;

  localparam int NI = nn_pkg::NUM_INPUTS;
  localparam int NC = nn_pkg::NUM_CLASSES;
  localparam int DW = nn_pkg::DATA_W;
  localparam int IW = nn_pkg::IDX_W;

  typedef logic [NI-1:0][DW-1:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_t                   input_vector = '0;
  logic                   valid_in = 1'b0;
  logic                   ready;
  logic [IW-1:0]          class_idx;
  logic signed [DW-1:0]   max_value;
  logic                   valid_out;
  logic                   overrun;
  nn_pkg::argmax_state_t  dbg_state;

  argmax_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .input_vector (input_vector),
    .valid_in     (valid_in),
    .ready        (ready),
    .class_idx    (class_idx),
    .max_value    (max_value),
    .valid_out    (valid_out),
    .overrun      (overrun),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest signed score among the scanned classes, first one on ties.
  function automatic logic [31:0] ref_result(input vec_t v);
    nn_pkg::score_t s;
    int best_v;
    int best_i;
    logic [31:0] r;
    s = v[0];
    best_v = int'(s);
    best_i = 0;
    for (int i = 1; i < NC; i++) begin
      s = v[i];
      if (int'(s) > best_v) begin
        best_v = int'(s);
        best_i = i;
      end
    end
    r = '0;
    r[DW+IW-1:DW] = IW'(best_i);
    r[DW-1:0]     = DW'(best_v);
    return r;
  endfunction

  function automatic logic [31:0] observed();
    logic [31:0] r;
    r = '0;
    r[DW+IW-1:DW] = class_idx;
    r[DW-1:0]     = max_value;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; valid_in is sampled on the following posedge.
  task automatic drive(input vec_t v, input bit expect_result);
    if (expect_result) exp_q.push_back(ref_result(v));
    input_vector = v;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat, output int cycles);
    int ready_low;
    ready_low = 0;
    cycles = 0;
    while (!valid_out && cycles < 40) begin
      if (!ready) ready_low++;
      @(negedge clk);
      cycles++;
    end
    if (!valid_out) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_latency"}, cycles, exp_lat);
      check({tag, "_ready_low"}, ready_low, exp_lat);
      check({tag, "_ready_done"}, {31'd0, ready}, 32'd1);
      if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'd1, 32'd0);
      else check({tag, "_result"}, observed(), exp_q.pop_front());
    end
  endtask

  task automatic count_vout(input int ncyc, output int hits);
    hits = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (valid_out) hits++;
    end
  endtask

  function automatic vec_t rand_vec(input int mode);
    vec_t v;
    for (int i = 0; i < NI; i++) begin
      case (mode)
        0:       v[i] = DW'($urandom_range(0, 65535));
        1:       v[i] = DW'(int'($urandom_range(0, 6)) - 3);
        default: v[i] = DW'(int'($urandom_range(0, 200)) - 32768);
      endcase
    end
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    vec_t v2;
    int   cyc;
    int   hits;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_class_idx", {28'd0, class_idx}, 32'd0);
    check("rst_max_value", {16'd0, max_value}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Distinct maximum
    v = '0;
    v[0] = DW'(5); v[1] = DW'(-3); v[2] = DW'(100); v[3] = DW'(7);
    drive(v, 1'b1);
    wait_result("distinct", NC - 1, cyc);
    check("distinct_pulse", {31'd0, valid_out}, 32'd1);
    @(negedge clk);
    check("distinct_one_cycle", {31'd0, valid_out}, 32'd0);

    // All negative with a tie at indices 1 and 2
    v = '0;
    v[0] = DW'(-50); v[1] = DW'(-7); v[2] = DW'(-7); v[3] = DW'(-300);
    for (int i = 4; i < 9; i++) v[i] = DW'(-1000 - i);
    v[9] = DW'(-32768);
    drive(v, 1'b1);
    wait_result("neg_tie", NC - 1, cyc);

    // Padding ignored
    v = '0;
    v[9] = DW'(10); v[12] = DW'(32767);
    drive(v, 1'b1);
    wait_result("padding", NC - 1, cyc);

    // Extremes
    for (int i = 0; i < NI; i++) v[i] = DW'(-1);
    v[0] = DW'(-32768); v[8] = DW'(32767);
    drive(v, 1'b1);
    wait_result("extremes", NC - 1, cyc);

    // Overrun: second strobe four edges into the scan is dropped
    v = '0;
    v[4] = DW'(1234);
    v2 = '0;
    v2[7] = DW'(9999);
    drive(v, 1'b1);
    repeat (3) @(negedge clk);
    drive(v2, 1'b0);
    check("overrun_pulse", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    check("overrun_one_cycle", {31'd0, overrun}, 32'd0);
    wait_result("overrun", NC - 6, cyc);
    count_vout(15, hits);
    check("overrun_single_vout", hits, 32'd0);

    // Back-to-back: new strobe in the DONE cycle
    v = '0;
    v[3] = DW'(77);
    v2 = '0;
    v2[6] = DW'(-5);
    for (int i = 0; i < NC; i++) if (i != 6) v2[i] = DW'(-20);
    drive(v, 1'b1);
    wait_result("b2b_first", NC - 1, cyc);
    drive(v2, 1'b1);
    wait_result("b2b_second", NC - 1, cyc);
    check("b2b_gap", cyc + 1, NC);

    // Reset mid-scan
    v = '0;
    v[5] = DW'(321);
    drive(v, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    check("midrst_class_idx", {28'd0, class_idx}, 32'd0);
    check("midrst_max_value", {16'd0, max_value}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    count_vout(15, hits);
    check("midrst_no_vout", hits, 32'd0);
    drive(v, 1'b1);
    wait_result("after_rst", NC - 1, cyc);

    // Randomized vectors with random idle gaps (zero gap = back-to-back)
    for (int k = 0; k < 40; k++) begin
      drive(rand_vec(k % 3), 1'b1);
      wait_result("random", NC - 1, cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    count_vout(12, hits);
    check("final_no_vout", hits, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
